// File: rtl/audio_pkg.sv
// Shared definitions for the audio playback/record datapath.
package audio_pkg;

  localparam int WORD_LENGTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SHIFT = 2'd2
  } deserializer_state_t;

endpackage

// File: rtl/bit_tick_generator.sv
// Free-running divider: tick_o is high for one cycle every CLOCK_DIVIDE cycles
// while clear_i is low; clear_i holds the count at zero.
module bit_tick_generator #(
  parameter int CLOCK_DIVIDE = 40
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLOCK_DIVIDE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCK_DIVIDE - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // next divider count: clear, wrap at the last count, otherwise advance
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // divider count register
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = (count_q == LAST);

endmodule

// File: rtl/audio_playback_deserializer.sv
// Playback deserializer: primes one word from the selected bank, then streams
// words MSB-first at CLOCK_DIVIDE cycles per bit through a one-word holding buffer.
module audio_playback_deserializer_checker (
  input logic clock_i,
  input logic reset_i,
  input logic boundary_i,
  input logic holding_valid_i
);

  holding_ready_at_boundary: assert property (
    @(posedge clock_i) disable iff (!reset_i) boundary_i |-> holding_valid_i);

endmodule

module audio_playback_deserializer #(
  parameter int WORD_LENGTH  = audio_pkg::WORD_LENGTH,
  parameter int CLOCK_DIVIDE = 40,
  parameter int MEM_LATENCY  = 1
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [WORD_LENGTH-1:0] memory_data_i,
  output logic                   word_request_o,
  output logic                   done_o,
  output logic                   audio_pwm_o,
  output logic                   audio_sd_o
);

  import audio_pkg::*;

  localparam int BIT_W   = $clog2(WORD_LENGTH);
  localparam int PRIME_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int CAP_W   = $clog2(MEM_LATENCY + 1);
  localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(WORD_LENGTH - 1);
  localparam logic [PRIME_W-1:0] LAST_PRIME = PRIME_W'(MEM_LATENCY - 1);
  localparam logic [CAP_W-1:0]   CAP_START  = CAP_W'(MEM_LATENCY);

  deserializer_state_t state_q, state_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic [WORD_LENGTH-1:0] hold_q, hold_d;
  logic                   hold_vld_q, hold_vld_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [PRIME_W-1:0]     prime_cnt_q, prime_cnt_d;
  logic                   cap_pend_q, cap_pend_d;
  logic [CAP_W-1:0]       cap_cnt_q, cap_cnt_d;
  logic                   word_req_q, word_req_d;
  logic                   done_q, done_d;
  logic                   pwm_q, pwm_d;
  logic                   sd_q, sd_d;

  logic bit_tick_s;
  logic clear_s;
  logic boundary_s;

  assign clear_s    = (state_q != SHIFT) || !enable_i;
  assign boundary_s = (state_q == SHIFT) && enable_i && bit_tick_s && (bit_cnt_q == LAST_BIT);

  bit_tick_generator #(
    .CLOCK_DIVIDE(CLOCK_DIVIDE)
  ) u_bit_tick (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear_i (clear_s),
    .tick_o  (bit_tick_s)
  );

  audio_playback_deserializer_checker u_checker (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .boundary_i      (boundary_s),
    .holding_valid_i (hold_vld_q)
  );

  // next-state, datapath and output computation
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    bit_cnt_d   = bit_cnt_q;
    prime_cnt_d = prime_cnt_q;
    cap_pend_d  = cap_pend_q;
    cap_cnt_d   = cap_cnt_q;
    word_req_d  = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = PRIME;
        end else begin
          state_d = IDLE;
        end
      end
      PRIME: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (prime_cnt_q == LAST_PRIME) begin
          shift_d     = memory_data_i;
          word_req_d  = 1'b1;
          prime_cnt_d = '0;
          bit_cnt_d   = '0;
          state_d     = SHIFT;
        end else begin
          prime_cnt_d = prime_cnt_q + PRIME_W'(1);
        end
      end
      SHIFT: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else begin
          // the request just issued makes new data valid MEM_LATENCY+1 cycles later
          if (word_req_q) begin
            cap_pend_d = 1'b1;
            cap_cnt_d  = CAP_START;
          end else if (cap_pend_q && (cap_cnt_q == '0)) begin
            hold_d     = memory_data_i;
            hold_vld_d = 1'b1;
            cap_pend_d = 1'b0;
          end else if (cap_pend_q) begin
            cap_cnt_d = cap_cnt_q - CAP_W'(1);
          end else begin
            cap_cnt_d = cap_cnt_q;
          end

          if (boundary_s) begin
            shift_d    = hold_q;
            hold_vld_d = 1'b0;
            bit_cnt_d  = '0;
            word_req_d = 1'b1;
            done_d     = 1'b1;
          end else if (bit_tick_s) begin
            shift_d   = {shift_q[WORD_LENGTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else begin
            shift_d = shift_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) begin
      shift_d     = '0;
      hold_d      = '0;
      hold_vld_d  = 1'b0;
      bit_cnt_d   = '0;
      prime_cnt_d = '0;
      cap_pend_d  = 1'b0;
      cap_cnt_d   = '0;
      word_req_d  = 1'b0;
      done_d      = 1'b0;
    end else begin
      hold_vld_d = hold_vld_d;
    end

    pwm_d = (state_d == SHIFT) ? shift_d[WORD_LENGTH-1] : 1'b0;
    sd_d  = (state_d != IDLE);
  end

  // state, datapath and registered-output flops
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      bit_cnt_q   <= '0;
      prime_cnt_q <= '0;
      cap_pend_q  <= 1'b0;
      cap_cnt_q   <= '0;
      word_req_q  <= 1'b0;
      done_q      <= 1'b0;
      pwm_q       <= 1'b0;
      sd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      bit_cnt_q   <= bit_cnt_d;
      prime_cnt_q <= prime_cnt_d;
      cap_pend_q  <= cap_pend_d;
      cap_cnt_q   <= cap_cnt_d;
      word_req_q  <= word_req_d;
      done_q      <= done_d;
      pwm_q       <= pwm_d;
      sd_q        <= sd_d;
    end
  end

  assign word_request_o = word_req_q;
  assign done_o         = done_q;
  assign audio_pwm_o    = pwm_q;
  assign audio_sd_o     = sd_q;

endmodule

// File: tb/tb_audio_playback_deserializer.sv
// Directed bench: three deserializer configurations fed by simple memory models,
// output bit streams checked against a queue of expected bits.
module tb_audio_playback_deserializer;

  logic clk;
  logic rst_n;
  logic en_a, en_b, en_c;
  logic req_a, done_a, pwm_a, sd_a;
  logic req_b, done_b, pwm_b, sd_b;
  logic req_c, done_c, pwm_c, sd_c;
  logic [3:0]  mem_data_a;
  logic [15:0] mem_data_b;
  logic [3:0]  mem_data_c;

  logic [3:0]  mem_a [8];
  logic [15:0] mem_b [16];
  logic [3:0]  mem_c [8];
  logic [2:0]  addr_a;
  logic [3:0]  addr_b;
  logic [2:0]  addr_c;
  logic [3:0]  pipe_a;
  logic [15:0] pipe_b;
  logic [3:0]  pipe_c [3];

  int errors = 0;
  int checks = 0;
  bit exp_q[$];
  int pulses[$];

  audio_playback_deserializer #(.WORD_LENGTH(4), .CLOCK_DIVIDE(2), .MEM_LATENCY(1)) dut_a (
    .clock_i(clk), .reset_i(rst_n), .enable_i(en_a), .memory_data_i(mem_data_a),
    .word_request_o(req_a), .done_o(done_a), .audio_pwm_o(pwm_a), .audio_sd_o(sd_a));

  audio_playback_deserializer #(.WORD_LENGTH(16), .CLOCK_DIVIDE(40), .MEM_LATENCY(1)) dut_b (
    .clock_i(clk), .reset_i(rst_n), .enable_i(en_b), .memory_data_i(mem_data_b),
    .word_request_o(req_b), .done_o(done_b), .audio_pwm_o(pwm_b), .audio_sd_o(sd_b));

  audio_playback_deserializer #(.WORD_LENGTH(4), .CLOCK_DIVIDE(2), .MEM_LATENCY(3)) dut_c (
    .clock_i(clk), .reset_i(rst_n), .enable_i(en_c), .memory_data_i(mem_data_c),
    .word_request_o(req_c), .done_o(done_c), .audio_pwm_o(pwm_c), .audio_sd_o(sd_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory models: address advances on each request, data lags by the latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_a <= 3'd0;
      addr_b <= 4'd0;
      addr_c <= 3'd0;
    end else begin
      if (req_a) addr_a <= addr_a + 3'd1;
      if (req_b) addr_b <= addr_b + 4'd1;
      if (req_c) addr_c <= addr_c + 3'd1;
    end
  end

  always @(posedge clk) begin
    pipe_a    <= mem_a[addr_a];
    pipe_b    <= mem_b[addr_b];
    pipe_c[0] <= mem_c[addr_c];
    pipe_c[1] <= pipe_c[0];
    pipe_c[2] <= pipe_c[1];
  end

  assign mem_data_a = pipe_a;
  assign mem_data_b = pipe_b;
  assign mem_data_c = pipe_c[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] word, input int wl, input int cd);
    for (int b = wl - 1; b >= 0; b--) begin
      for (int k = 0; k < cd; k++) exp_q.push_back(word[b]);
    end
  endtask

  function automatic bit pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    else return 1'b0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt;
    int sd_gaps;
    int done_cnt;
    rst_n = 1'b0;
    en_a = 1'b1;
    en_b = 1'b0;
    en_c = 1'b0;
    mem_a[0] = 4'b1011; mem_a[1] = 4'b0110; mem_a[2] = 4'b1001; mem_a[3] = 4'b1101;
    mem_a[4] = 4'b0010; mem_a[5] = 4'b1110; mem_a[6] = 4'b0001; mem_a[7] = 4'b1000;
    mem_c[0] = 4'b1100; mem_c[1] = 4'b0011; mem_c[2] = 4'b1010; mem_c[3] = 4'b0111;
    mem_c[4] = 4'b1110; mem_c[5] = 4'b0101; mem_c[6] = 4'b1001; mem_c[7] = 4'b0110;
    for (int i = 0; i < 16; i++) mem_b[i] = 16'($urandom);

    // reset with enable already high
    repeat (2) @(negedge clk);
    check("reset_outs_a", 32'({pwm_a, sd_a, req_a, done_a}), 32'h0);
    check("reset_outs_b", 32'({pwm_b, sd_b, req_b, done_b}), 32'h0);
    check("reset_outs_c", 32'({pwm_c, sd_c, req_c, done_c}), 32'h0);
    rst_n = 1'b1;

    @(negedge clk);
    check("prime_sd_a", 32'(sd_a), 32'h1);
    check("prime_req_a", 32'(req_a), 32'h0);
    check("prime_pwm_a", 32'(pwm_a), 32'h0);

    // three words, then enable drops in the tick cycle that ends word three
    exp_q.delete();
    for (int w = 0; w < 3; w++) push_word(16'(mem_a[w]), 4, 2);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check("stream_pwm_a", 32'(pwm_a), 32'(pop_exp()));
      check("stream_req_a", 32'(req_a), 32'((i % 8) == 0));
      check("stream_done_a", 32'(done_a), 32'(((i % 8) == 0) && (i > 0)));
      check("stream_sd_a", 32'(sd_a), 32'h1);
      if (i == 23) en_a = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("disable_idle_a", 32'({pwm_a, sd_a, req_a, done_a}), 32'h0);
    end

    // restart, then asynchronous reset in the middle of a bit
    en_a = 1'b1;
    @(negedge clk);
    check("reprime_sd_a", 32'(sd_a), 32'h1);
    check("reprime_req_a", 32'(req_a), 32'h0);
    @(negedge clk);
    check("restart_req_a", 32'(req_a), 32'h1);
    check("restart_pwm_a", 32'(pwm_a), 32'(mem_a[3][3]));
    @(negedge clk);
    check("pre_reset_sd_a", 32'(sd_a), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_a", 32'({pwm_a, sd_a, req_a, done_a}), 32'h0);
    en_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle_a", 32'({pwm_a, sd_a, req_a, done_a}), 32'h0);
    en_a = 1'b1;
    @(negedge clk);
    check("fresh_prime_sd_a", 32'(sd_a), 32'h1);
    check("fresh_prime_req_a", 32'(req_a), 32'h0);
    @(negedge clk);
    check("fresh_req_a", 32'(req_a), 32'h1);
    check("fresh_done_a", 32'(done_a), 32'h0);
    check("fresh_pwm_a", 32'(pwm_a), 32'(mem_a[0][3]));
    en_a = 1'b0;
    @(negedge clk);
    check("fresh_stop_a", 32'({pwm_a, sd_a, req_a, done_a}), 32'h0);

    // ten full-size words: request spacing, continuous amplifier enable
    exp_q.delete();
    for (int w = 0; w < 10; w++) push_word(mem_b[w], 16, 40);
    en_b = 1'b1;
    wt = 0;
    while (!req_b && wt < 10) begin
      @(negedge clk);
      wt++;
    end
    check("start_req_b", 32'(req_b), 32'h1);
    sd_gaps = 0;
    done_cnt = 0;
    pulses.delete();
    for (int cyc = 0; cyc < 6400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      check("stream_pwm_b", 32'(pwm_b), 32'(pop_exp()));
      if (req_b) pulses.push_back(cyc);
      if (done_b) done_cnt++;
      if (!sd_b) sd_gaps++;
    end
    check("req_count_b", 32'(pulses.size()), 32'd10);
    check("done_count_b", 32'(done_cnt), 32'd9);
    check("sd_gaps_b", 32'(sd_gaps), 32'd0);
    for (int p = 1; p < pulses.size(); p++) begin
      check("req_spacing_b", 32'(pulses[p] - pulses[p-1]), 32'd640);
    end
    en_b = 1'b0;
    @(negedge clk);
    check("stop_b", 32'({pwm_b, sd_b, req_b, done_b}), 32'h0);

    // longer memory latency: three PRIME cycles, later holding capture
    exp_q.delete();
    for (int w = 0; w < 4; w++) push_word(16'(mem_c[w]), 4, 2);
    en_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("prime_sd_c", 32'(sd_c), 32'h1);
      check("prime_req_c", 32'(req_c), 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("stream_pwm_c", 32'(pwm_c), 32'(pop_exp()));
      check("stream_req_c", 32'(req_c), 32'((i % 8) == 0));
      check("stream_done_c", 32'(done_c), 32'(((i % 8) == 0) && (i > 0)));
    end
    en_c = 1'b0;
    @(negedge clk);
    check("stop_c", 32'({pwm_c, sd_c, req_c, done_c}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
